uart_tx_framer: RTL and testbench

Parametrised UART transmit framer: accepts one data word per valid/ready handshake and serialises it onto a single line. Frame order is start bit, LSB-first data, optional even/odd parity, then 1 or 2 stop bits. It contains its own baud-rate divider, so it runs on the system clock rather than a pre-divided baud clock. It sits between a byte-producing client (FIFO, command engine) and the board TX pin, and is the generalised successor of the fixed-format transmitter.

---
 rtl/uart_tx_framer.sv | 158 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: parametrised UART transmit framer with built-in baud divider.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// then STOP_BITS stop bits. Every bit is held CLKS_PER_BIT clock cycles.
module uart_tx_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 2,
  parameter int PARITY_MODE  = 0,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  tx_clk,
  input  logic                  rst_n,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx_dout,
  output logic                  tx_busy,
  output logic                  tx_done
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_framer: DATA_WIDTH must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_framer: PARITY_MODE must be 0, 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_framer: CLKS_PER_BIT must be at least 2");
  end

  localparam int BAUD_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [3:0]            r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parity;
  logic                  r_dout;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;

  logic w_bit_end;
  logic w_parity;

  // Last cycle of the current bit period.
  assign w_bit_end = (r_baud == BAUD_LAST);

  // Parity of the incoming word; only meaningful when a parity bit is sent.
  assign w_parity = (PARITY_MODE == 2) ? ~^data_in :
                    (PARITY_MODE == 1) ?  ^data_in : 1'b0;

  // Frame sequencer: baud divider, bit counter, shifter and registered outputs.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_dout   <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The divider only runs inside a frame; it is already 0 on leaving IDLE.
      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_shift  <= data_in;
            r_parity <= w_parity;
            r_state  <= S_START;
            r_dout   <= 1'b0;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_dout  <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == DATA_LAST) begin
              r_bit <= '0;
              if (PARITY_MODE != 0) begin
                r_state <= S_PARITY;
                r_dout  <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_dout  <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_dout  <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_bit   <= '0;
            r_dout  <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit == STOP_LAST) begin
              r_state <= S_IDLE;
              r_bit   <= '0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_bit   <= '0;
          r_dout  <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tx_dout  = r_dout;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: three differently configured instances driven
// with directed and random words; a scoreboard per instance checks every
// transmitted bit period plus the control outputs against a frame model.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] dout;
  logic [2:0] bsy;
  logic [2:0] dn;
  logic [8:0] din [3];

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [3][$];
  int          gap_last [3];

  always #5 clk = ~clk;

  // inst 0: 8 data, no parity, 1 stop, 4 clk/bit
  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_MODE(0), .CLKS_PER_BIT(4)) u_dut0 (
    .tx_clk(clk), .rst_n(rst_n), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .data_in(din[0][7:0]), .tx_dout(dout[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

  // inst 1: 8 data, odd parity, 2 stop, 4 clk/bit
  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(2), .PARITY_MODE(2), .CLKS_PER_BIT(4)) u_dut1 (
    .tx_clk(clk), .rst_n(rst_n), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .data_in(din[1][7:0]), .tx_dout(dout[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

  // inst 2: 5 data, even parity, 1 stop, 2 clk/bit
  uart_tx_framer #(.DATA_WIDTH(5), .STOP_BITS(1), .PARITY_MODE(1), .CLKS_PER_BIT(2)) u_dut2 (
    .tx_clk(clk), .rst_n(rst_n), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .data_in(din[2][4:0]), .tx_dout(dout[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

  function automatic int dw(input int id);
    return (id == 2) ? 5 : 8;
  endfunction
  function automatic int sb(input int id);
    return (id == 1) ? 2 : 1;
  endfunction
  function automatic int pm(input int id);
    return (id == 0) ? 0 : ((id == 1) ? 2 : 1);
  endfunction
  function automatic int cpb(input int id);
    return (id == 2) ? 2 : 4;
  endfunction
  function automatic int frame_bits(input int id);
    return 1 + dw(id) + ((pm(id) != 0) ? 1 : 0) + sb(id);
  endfunction

  // Line level for each bit slot of a frame: index 0 is the start bit.
  function automatic logic [15:0] model_frame(input int id, input logic [8:0] d);
    logic [15:0] f;
    int ones;
    int n;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    n    = 1;
    for (int i = 0; i < dw(id); i++) begin
      f[n] = d[i];
      ones = ones + int'(d[i]);
      n++;
    end
    if (pm(id) == 1) f[n] = (ones % 2 == 1);
    if (pm(id) == 2) f[n] = (ones % 2 == 0);
    return f;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h", name, id, got, exp);
    end
  endtask

  // Offer one word; push its expected frame once the handshake is certain.
  task automatic send(input int id, input logic [8:0] d);
    int t;
    din[id] = d;
    vld[id] = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (rdy[id] && rst_n) break;
      t++;
      if (t > 500) begin
        chk("handshake_timeout", id, 32'd0, 32'd1);
        vld[id] = 1'b0;
        return;
      end
    end
    exp_q[id].push_back(model_frame(id, d));
    @(posedge clk);
    #1;
    vld[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (bsy == 3'b000 && rdy == 3'b111 && exp_q[0].size() == 0 &&
          exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      t++;
      if (t > 3000) begin
        chk("idle_timeout", 0, 32'd0, 32'd1);
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic monitor(input int id);
    logic        prev_rst;
    logic        rst_hit;
    logic        in_frame;
    logic [15:0] fb;
    int          j, c, flen, pat, exp_pat, ctl_bad, since_done;
    prev_rst   = 1'b1;
    in_frame   = 1'b0;
    fb         = '1;
    j          = 0;
    pat        = 0;
    ctl_bad    = 0;
    since_done = 1000;
    c          = cpb(id);
    flen       = frame_bits(id) * c;
    forever begin
      @(negedge clk);
      rst_hit  = prev_rst;
      prev_rst = !rst_n;
      if (rst_hit) begin
        chk("reset_state", id, 32'({dout[id], rdy[id], bsy[id], dn[id]}), 32'b1100);
        in_frame   = 1'b0;
        since_done = 1000;
        continue;
      end
      if (in_frame && j == flen) begin
        chk("ctl_in_frame", id, 32'(ctl_bad), 32'd0);
        chk("done_cycle", id, 32'({dout[id], rdy[id], bsy[id], dn[id]}), 32'b1101);
        in_frame   = 1'b0;
        since_done = 0;
        continue;
      end
      if (!in_frame) begin
        if (dn[id]) chk("stray_done", id, 32'd1, 32'd0);
        if (bsy[id]) begin
          if (exp_q[id].size() == 0) begin
            chk("stray_frame", id, 32'd1, 32'd0);
            fb = '1;
          end else begin
            fb = exp_q[id].pop_front();
          end
          gap_last[id] = since_done;
          in_frame = 1'b1;
          j        = 0;
          pat      = 0;
          ctl_bad  = 0;
        end else begin
          if (since_done < 1000) since_done++;
          if (dout[id] !== 1'b1) chk("idle_line", id, 32'(dout[id]), 32'd1);
        end
      end
      if (in_frame) begin
        pat = (pat << 1) | int'(dout[id]);
        if (rdy[id] || !bsy[id] || dn[id]) ctl_bad++;
        if (j % c == c - 1) begin
          exp_pat = fb[j / c] ? ((1 << c) - 1) : 0;
          chk($sformatf("bit%0d", j / c), id, 32'(pat & ((1 << c) - 1)), 32'(exp_pat));
          pat = 0;
        end
        j++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    int         id;
    int         f1;
    rst_n  = 1'b0;
    vld    = 3'b000;
    din[0] = '0;
    din[1] = '0;
    din[2] = '0;
    gap_last[0] = -1;
    gap_last[1] = -1;
    gap_last[2] = -1;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed frames from each configuration
    send(0, 9'h0A5);
    send(1, 9'h0A5);
    send(2, 9'h01F);
    wait_idle();
    send(1, 9'h007);
    wait_idle();

    // back-to-back with valid held: next frame starts right after the done cycle
    send(1, 9'h03C);
    send(1, 9'h0C3);
    wait_idle();
    chk("b2b_gap", 1, 32'(gap_last[1]), 32'd0);
    send(0, 9'h03C);
    send(0, 9'h0C3);
    wait_idle();
    chk("b2b_gap", 0, 32'(gap_last[0]), 32'd0);

    // valid held and data_in scrambled while the frame is on the line
    f1 = frame_bits(1) * cpb(1);
    send(1, 9'h05A);
    vld[1] = 1'b1;
    for (int i = 1; i <= f1 - 2; i++) begin
      @(posedge clk);
      #1;
      din[1] = 9'($urandom);
    end
    vld[1] = 1'b0;
    wait_idle();

    // random traffic across all three instances
    for (int n = 0; n < 40; n++) begin
      id = int'($urandom_range(0, 2));
      d  = 9'($urandom) & ((id == 2) ? 9'h01F : 9'h0FF);
      send(id, d);
    end
    wait_idle();

    // one-cycle reset in the middle of the data bits, valid held high
    send(0, 9'h096);
    repeat (9) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    vld[0] = 1'b1;
    din[0] = 9'h0FF;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    vld[0] = 1'b0;
    send(0, 9'h055);
    wait_idle();
    repeat (4) @(posedge clk);

    for (int k = 0; k < 3; k++) begin
      chk("queue_empty", k, 32'(exp_q[k].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
